// File: rtl/pad_io_pkg.sv
// pad_io_pkg: shared constants, types and helpers for the pad I/O bridge.
package pad_io_pkg;

  localparam int unsigned DEF_DATA_W     = 15;
  localparam int unsigned DEF_NUM_CH     = 2;
  localparam int unsigned DEF_FIFO_DEPTH = 8;
  localparam int unsigned DEF_NUM_CLASS  = 3;
  localparam int unsigned DEF_OUT_HOLD   = 2;

  // Bit width needed to index n items, never less than 1.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned DEF_CH_W = clog2_min1(DEF_NUM_CH);

  typedef struct packed {
    logic [DEF_CH_W-1:0]   ch;
    logic [DEF_DATA_W-1:0] data;
  } beat_t;

  typedef enum logic {
    IDLE,
    DRIVE
  } out_state_t;

endpackage

// File: rtl/pad_io_fifo.sv
// pad_io_fifo: generic first-word-fall-through FIFO; DEPTH must be a power of 2.
module pad_io_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = rd_en && !empty;
  // A full FIFO still takes a write when the head leaves on the same edge.
  assign do_push = wr_en && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pad_io_bridge.sv
// pad_io_bridge: pad ring <-> core bridge. Input beats are sampled, tagged and
// queued; results are held on the output pads for OUT_HOLD cycles.
// Optional macro PAD_IO_STATS_EN adds rx_count / drop_count statistics ports.
module pad_io_bridge
  import pad_io_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned NUM_CH     = DEF_NUM_CH,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned NUM_CLASS  = DEF_NUM_CLASS,
  parameter int unsigned OUT_HOLD   = DEF_OUT_HOLD
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_CH-1:0]               pad_in_valid,
  input  logic [DATA_W-1:0]               pad_in_data,
  output logic                            core_valid,
  input  logic                            core_ready,
  output logic [clog2_min1(NUM_CH)-1:0]   core_ch,
  output logic [DATA_W-1:0]               core_data,
  input  logic                            res_valid,
  output logic                            res_ready,
  input  logic [NUM_CLASS-1:0]            res_class,
  output logic                            pad_out_valid,
  output logic [NUM_CLASS-1:0]            pad_out_class,
  output logic                            ovf_err,
  output logic                            coll_err
`ifdef PAD_IO_STATS_EN
  ,
  output logic [15:0]                     rx_count,
  output logic [7:0]                      drop_count
`endif
);

  localparam int unsigned CH_W = clog2_min1(NUM_CH);
  localparam int unsigned HW   = clog2_min1(OUT_HOLD);
  localparam int unsigned BW   = CH_W + DATA_W;
  localparam int unsigned CW   = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [CH_W-1:0]   ch;
    logic [DATA_W-1:0] data;
  } beat_w_t;

  logic [NUM_CH-1:0] s_valid;
  logic [DATA_W-1:0] s_data;
  logic [CH_W-1:0]   s_ch;
  logic              found;
  logic              wr_en;
  logic              pop;
  logic              drop;
  logic              collision;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  beat_w_t           wr_beat;
  beat_w_t           rd_beat;

  out_state_t        state;
  logic [HW-1:0]     hold_cnt;

  // Stage S: register the raw pad inputs every edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_valid <= '0;
      s_data  <= '0;
    end else begin
      s_valid <= pad_in_valid;
      s_data  <= pad_in_data;
    end
  end

  // Lowest set valid bit selects the channel tag.
  always_comb begin
    s_ch  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (s_valid[i] && !found) begin
        s_ch  = CH_W'(i);
        found = 1'b1;
      end
    end
  end

  assign wr_en        = |s_valid;
  assign collision    = (s_valid & (s_valid - NUM_CH'(1))) != '0;
  assign wr_beat.ch   = s_ch;
  assign wr_beat.data = s_data;
  assign pop          = core_ready && !fifo_empty;
  assign drop         = wr_en && fifo_full && !pop;
  assign core_valid   = (fifo_count != '0);
  assign core_ch      = rd_beat.ch;
  assign core_data    = rd_beat.data;

  pad_io_fifo #(
    .WIDTH (BW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_beat),
    .rd_en   (core_ready),
    .rd_data (rd_beat),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_err  <= 1'b0;
      coll_err <= 1'b0;
    end else begin
      if (drop)      ovf_err  <= 1'b1;
      if (collision) coll_err <= 1'b1;
    end
  end

`ifdef PAD_IO_STATS_EN
  // Saturating accepted/dropped beat counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_count   <= '0;
      drop_count <= '0;
    end else begin
      if (wr_en && !drop && (rx_count != '1)) rx_count <= rx_count + 16'd1;
      if (drop && (drop_count != '1))         drop_count <= drop_count + 8'd1;
    end
  end
`endif

  // Output FSM: latch a result and hold it on the pads for OUT_HOLD cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      hold_cnt      <= '0;
      res_ready     <= 1'b1;
      pad_out_valid <= 1'b0;
      pad_out_class <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (res_valid) begin
            pad_out_class <= res_class;
            pad_out_valid <= 1'b1;
            hold_cnt      <= HW'(OUT_HOLD - 1);
            res_ready     <= 1'b0;
            state         <= DRIVE;
          end
        end
        DRIVE: begin
          if (hold_cnt == '0) begin
            pad_out_valid <= 1'b0;
            pad_out_class <= '0;
            res_ready     <= 1'b1;
            state         <= IDLE;
          end else begin
            hold_cnt <= hold_cnt - HW'(1);
          end
        end
        default: begin
          state     <= IDLE;
          res_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pad_io_bridge.sv
// tb_pad_io_bridge: directed checks for pad_io_bridge in its default configuration.
module tb_pad_io_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  pad_in_valid;
  logic [14:0] pad_in_data;
  logic        core_valid;
  logic        core_ready;
  logic [0:0]  core_ch;
  logic [14:0] core_data;
  logic        res_valid;
  logic        res_ready;
  logic [2:0]  res_class;
  logic        pad_out_valid;
  logic [2:0]  pad_out_class;
  logic        ovf_err;
  logic        coll_err;
`ifdef PAD_IO_STATS_EN
  logic [15:0] rx_count;
  logic [7:0]  drop_count;
`endif

  int total = 0;
  int bad   = 0;

  pad_io_bridge dut (
    .clk           (clk),
    .rst           (rst),
    .pad_in_valid  (pad_in_valid),
    .pad_in_data   (pad_in_data),
    .core_valid    (core_valid),
    .core_ready    (core_ready),
    .core_ch       (core_ch),
    .core_data     (core_data),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_class     (res_class),
    .pad_out_valid (pad_out_valid),
    .pad_out_class (pad_out_class),
    .ovf_err       (ovf_err),
    .coll_err      (coll_err)
`ifdef PAD_IO_STATS_EN
    ,
    .rx_count      (rx_count),
    .drop_count    (drop_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [5:0] pat;
    pat          = 6'b011011;
    rst          = 1'b1;
    pad_in_valid = '0;
    pad_in_data  = '0;
    core_ready   = 1'b0;
    res_valid    = 1'b0;
    res_class    = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_core_valid", core_valid, 0);
    chk("rst_res_ready", res_ready, 1);
    chk("rst_pad_out_valid", pad_out_valid, 0);
    chk("rst_pad_out_class", pad_out_class, 0);
    chk("rst_ovf", ovf_err, 0);
    chk("rst_coll", coll_err, 0);

    // Single beat on channel 1
    core_ready   = 1'b1;
    pad_in_valid = 2'b10;
    pad_in_data  = 15'h1234;
    tick();
    pad_in_valid = 2'b00;
    chk("single_lat1", core_valid, 0);
    tick();
    chk("single_valid", core_valid, 1);
    chk("single_ch", core_ch, 1);
    chk("single_data", core_data, 32'h1234);
    tick();
    chk("single_gone", core_valid, 0);

    // Overflow: ten beats into an eight-deep queue
    do_reset();
    core_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      pad_in_valid = 2'b01;
      pad_in_data  = 15'(i);
      tick();
    end
    pad_in_valid = 2'b00;
    tick();
    tick();
    chk("ovf_flag", ovf_err, 1);
    chk("ovf_no_coll", coll_err, 0);
`ifdef PAD_IO_STATS_EN
    chk("ovf_rx_count", rx_count, 8);
    chk("ovf_drop_count", drop_count, 2);
`endif
    core_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("ovf_drain_valid", core_valid, 1);
      chk("ovf_drain_data", core_data, i);
      chk("ovf_drain_ch", core_ch, 0);
      tick();
    end
    chk("ovf_drained", core_valid, 0);

    // Collision: both channels at once
    do_reset();
    pad_in_valid = 2'b11;
    pad_in_data  = 15'h0055;
    tick();
    pad_in_valid = 2'b00;
    tick();
    chk("coll_valid", core_valid, 1);
    chk("coll_ch", core_ch, 0);
    chk("coll_data", core_data, 32'h55);
    chk("coll_flag", coll_err, 1);
    tick();
    chk("coll_one_beat", core_valid, 0);
    chk("coll_no_ovf", ovf_err, 0);

    // Simultaneous push and pop while full
    do_reset();
    core_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pad_in_valid = 2'b01;
      pad_in_data  = 15'(32'h100 + i);
      tick();
    end
    pad_in_valid = 2'b00;
    tick();
    chk("full_head", core_data, 32'h100);
    chk("full_no_ovf", ovf_err, 0);
    pad_in_valid = 2'b01;
    pad_in_data  = 15'h7FFF;
    tick();
    pad_in_valid = 2'b00;
    core_ready   = 1'b1;
    tick();
    core_ready   = 1'b0;
    chk("pp_no_ovf", ovf_err, 0);
`ifdef PAD_IO_STATS_EN
    chk("pp_rx_count", rx_count, 9);
    chk("pp_drop_count", drop_count, 0);
`endif
    core_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      chk("pp_data", core_data, 32'h100 + i);
      tick();
    end
    chk("pp_last_valid", core_valid, 1);
    chk("pp_last_data", core_data, 32'h7FFF);
    tick();
    chk("pp_empty", core_valid, 0);

    // Output hold with res_valid held high
    chk("hold_ready_idle", res_ready, 1);
    res_class = 3'b010;
    res_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("hold_valid", pad_out_valid, pat[k]);
      chk("hold_class", pad_out_class, pat[k] ? 3'b010 : 3'b000);
      chk("hold_ready", res_ready, !pat[k]);
    end
    res_valid = 1'b0;
    tick();

    // Reset during DRIVE with three beats queued and an error raised
    core_ready   = 1'b0;
    pad_in_valid = 2'b11;
    pad_in_data  = 15'h0011;
    tick();
    pad_in_valid = 2'b01;
    pad_in_data  = 15'h0022;
    tick();
    pad_in_data  = 15'h0033;
    tick();
    pad_in_valid = 2'b00;
    tick();
    res_class = 3'b101;
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    chk("pre_rst_drive", pad_out_valid, 1);
    chk("pre_rst_class", pad_out_class, 3'b101);
    chk("pre_rst_queued", core_valid, 1);
    chk("pre_rst_coll", coll_err, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_pad_out_valid", pad_out_valid, 0);
    chk("mid_rst_pad_out_class", pad_out_class, 0);
    chk("mid_rst_core_valid", core_valid, 0);
    chk("mid_rst_res_ready", res_ready, 1);
    chk("mid_rst_ovf", ovf_err, 0);
    chk("mid_rst_coll", coll_err, 0);
    tick();
    chk("post_rst_core_valid", core_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
